// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding control for the 5-stage pipeline. It shadows the EX/MEM destination
// tags, drives the operand bypass selects and load-use stall/bubble, and counts stall cycles.
module hazard_forward_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_regwr,
    input  logic                  id_memtoreg,
    input  logic                  flush,
    output logic                  ex_forward_a,
    output logic                  ex_forward_b,
    output logic                  mem_forward_a,
    output logic                  mem_forward_b,
    output logic                  stall,
    output logic                  id_ex_bubble,
    output logic [CNT_W-1:0]      stall_count
);

    logic                  ex_vld_p1;
    logic [REG_ADDR_W-1:0] ex_dest_p1;
    logic                  ex_regwr_p1;
    logic                  ex_load_p1;
    logic                  mem_vld_p2;
    logic [REG_ADDR_W-1:0] mem_dest_p2;
    logic                  mem_regwr_p2;
    logic                  mem_load_p2;

    logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
    logic ex_fwd_a, ex_fwd_b, load_use;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // ID stage: compare source registers against the shadow EX/MEM tags
    always_comb begin
        ex_hit_a  = id_valid & id_use_rs & (id_rs != '0) & ex_vld_p1 & ex_regwr_p1 &
                    (ex_dest_p1 == id_rs);
        ex_hit_b  = id_valid & id_use_rt & (id_rt != '0) & ex_vld_p1 & ex_regwr_p1 &
                    (ex_dest_p1 == id_rt);
        mem_hit_a = id_valid & id_use_rs & (id_rs != '0) & mem_vld_p2 & mem_regwr_p2 &
                    (mem_dest_p2 == id_rs);
        mem_hit_b = id_valid & id_use_rt & (id_rt != '0) & mem_vld_p2 & mem_regwr_p2 &
                    (mem_dest_p2 == id_rt);

        // A load in EX only has its address on ALUout, so it can never be bypassed from there
        ex_fwd_a  = ex_hit_a & ~ex_load_p1;
        ex_fwd_b  = ex_hit_b & ~ex_load_p1;
        load_use  = ex_load_p1 & (ex_hit_a | ex_hit_b);

        ex_forward_a  = rst & ex_fwd_a;
        ex_forward_b  = rst & ex_fwd_b;
        mem_forward_a = rst & ~ex_fwd_a & mem_hit_a;
        mem_forward_b = rst & ~ex_fwd_b & mem_hit_b;
        stall         = rst & load_use & ~flush;
        id_ex_bubble  = rst & (load_use | flush);
    end

    // ID -> EX (p1) -> MEM (p2) shadow tag pipeline and stall counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_vld_p1    <= 1'b0;
            ex_dest_p1   <= '0;
            ex_regwr_p1  <= 1'b0;
            ex_load_p1   <= 1'b0;
            mem_vld_p2   <= 1'b0;
            mem_dest_p2  <= '0;
            mem_regwr_p2 <= 1'b0;
            mem_load_p2  <= 1'b0;
            stall_count  <= '0;
        end else begin
            mem_vld_p2   <= ex_vld_p1;
            mem_dest_p2  <= ex_dest_p1;
            mem_regwr_p2 <= ex_regwr_p1;
            mem_load_p2  <= ex_load_p1;
            if (id_ex_bubble) begin
                ex_vld_p1   <= 1'b0;
                ex_dest_p1  <= '0;
                ex_regwr_p1 <= 1'b0;
                ex_load_p1  <= 1'b0;
            end else begin
                ex_vld_p1   <= id_valid;
                ex_dest_p1  <= id_dest;
                ex_regwr_p1 <= id_regwr;
                ex_load_p1  <= id_memtoreg;
            end
            if (stall) begin
                stall_count <= sat_inc(stall_count);
            end
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: directed scenarios with literal expectations plus random
// traffic, all compared every cycle against a rule-level model of the hazard unit.
module tb_hazard_forward_unit;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_dest;
    logic       id_use_rs, id_use_rt, id_regwr, id_memtoreg, flush;
    logic       ex_forward_a, ex_forward_b, mem_forward_a, mem_forward_b, stall, id_ex_bubble;
    logic [15:0] stall_count;
    logic       s_efa, s_efb, s_mfa, s_mfb, s_stall, s_bub;
    logic [1:0] s_count;

    int checks = 0;
    int failures = 0;

    hazard_forward_unit #(.REG_ADDR_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest), .id_regwr(id_regwr),
        .id_memtoreg(id_memtoreg), .flush(flush), .ex_forward_a(ex_forward_a),
        .ex_forward_b(ex_forward_b), .mem_forward_a(mem_forward_a),
        .mem_forward_b(mem_forward_b), .stall(stall), .id_ex_bubble(id_ex_bubble),
        .stall_count(stall_count)
    );

    hazard_forward_unit #(.REG_ADDR_W(5), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest), .id_regwr(id_regwr),
        .id_memtoreg(id_memtoreg), .flush(flush), .ex_forward_a(s_efa),
        .ex_forward_b(s_efb), .mem_forward_a(s_mfa), .mem_forward_b(s_mfb),
        .stall(s_stall), .id_ex_bubble(s_bub), .stall_count(s_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: the two in-flight instructions ahead of ID, described by what they write
    typedef struct packed {
        bit       v;
        bit [4:0] d;
        bit       wr;
        bit       ld;
    } shadow_t;

    shadow_t     m_ex, m_mem;
    int unsigned m_cnt16, m_cnt2;

    function automatic bit hit(shadow_t s, logic [4:0] r, logic use_r);
        return id_valid && use_r && (r != 5'd0) && s.v && s.wr && (s.d == r);
    endfunction

    task automatic model_eval(output bit efa, output bit efb, output bit mfa, output bit mfb,
                              output bit st, output bit bub);
        bit exa, exb, lu;
        exa = hit(m_ex, id_rs, id_use_rs);
        exb = hit(m_ex, id_rt, id_use_rt);
        lu  = m_ex.ld && (exa || exb);
        efa = exa && !m_ex.ld;
        efb = exb && !m_ex.ld;
        mfa = !efa && hit(m_mem, id_rs, id_use_rs);
        mfb = !efb && hit(m_mem, id_rt, id_use_rt);
        st  = lu && !flush;
        bub = lu || flush;
        if (!rst) begin
            efa = 0; efb = 0; mfa = 0; mfb = 0; st = 0; bub = 0;
        end
    endtask

    task automatic model_clear();
        m_ex = '0;
        m_mem = '0;
        m_cnt16 = 0;
        m_cnt2 = 0;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        bit efa, efb, mfa, mfb, st, bub;
        model_eval(efa, efb, mfa, mfb, st, bub);
        chk("ex_forward_a", ex_forward_a, efa);
        chk("ex_forward_b", ex_forward_b, efb);
        chk("mem_forward_a", mem_forward_a, mfa);
        chk("mem_forward_b", mem_forward_b, mfb);
        chk("stall", stall, st);
        chk("id_ex_bubble", id_ex_bubble, bub);
        chk("stall_count", stall_count, m_cnt16);
        chk("stall_count_sat", s_count, m_cnt2);
        chk("stall_sat_inst", s_stall, st);
    endtask

    task automatic set_id(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                          input int dest, input bit wr, input bit ld, input bit fl);
        id_valid = v;
        id_rs = 5'(rs);
        id_rt = 5'(rt);
        id_use_rs = urs;
        id_use_rt = urt;
        id_dest = 5'(dest);
        id_regwr = wr;
        id_memtoreg = ld;
        flush = fl;
    endtask

    // Drive an ID-stage instruction and compare at the following falling edge
    task automatic go(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                      input int dest, input bit wr, input bit ld, input bit fl);
        set_id(v, rs, rt, urs, urt, dest, wr, ld, fl);
        @(negedge clk);
        compare_all();
    endtask

    task automatic step();
        bit efa, efb, mfa, mfb, st, bub;
        @(posedge clk);
        model_eval(efa, efb, mfa, mfb, st, bub);
        if (rst) begin
            if (st) begin
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            m_mem = m_ex;
            if (bub) m_ex = '0;
            else m_ex = '{v: id_valid, d: id_dest, wr: id_regwr, ld: id_memtoreg};
        end
        #1;
    endtask

    task automatic nop2();
        go(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        go(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    endtask

    initial begin
        bit hold;
        model_clear();
        rst = 1'b0;
        set_id(1, 9, 9, 1, 1, 9, 1, 1, 1);
        #12;
        chk("rst_ex_forward_a", ex_forward_a, 0);
        chk("rst_mem_forward_b", mem_forward_b, 0);
        chk("rst_stall", stall, 0);
        chk("rst_bubble", id_ex_bubble, 0);
        chk("rst_count", stall_count, 0);
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            go(0, 3, 4, 1, 1, 3, 1, 0, 0);
            chk("idle_outputs", {ex_forward_a, ex_forward_b, mem_forward_a, mem_forward_b,
                                 stall, id_ex_bubble}, 0);
            step();
        end

        // EX forward
        go(1, 0, 0, 0, 0, 5, 1, 0, 0); step();
        go(1, 5, 0, 1, 0, 0, 0, 0, 0);
        chk("exfwd_efa", ex_forward_a, 1);
        chk("exfwd_mfa", mem_forward_a, 0);
        chk("exfwd_stall", stall, 0);
        step(); nop2();

        // MEM forward, then EX-over-MEM priority
        go(1, 0, 0, 0, 0, 7, 1, 0, 0); step();
        go(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        go(1, 0, 7, 0, 1, 0, 0, 0, 0);
        chk("memfwd_mfb", mem_forward_b, 1);
        chk("memfwd_efb", ex_forward_b, 0);
        step(); nop2();
        go(1, 0, 0, 0, 0, 7, 1, 0, 0); step();
        go(1, 0, 0, 0, 0, 7, 1, 0, 0); step();
        go(1, 7, 0, 1, 0, 0, 0, 0, 0);
        chk("prio_efa", ex_forward_a, 1);
        chk("prio_mfa", mem_forward_a, 0);
        step(); nop2();

        // Load-use: one stall cycle, then MEM bypass
        go(1, 0, 0, 0, 0, 9, 1, 1, 0); step();
        go(1, 9, 0, 1, 0, 0, 0, 0, 0);
        chk("lu_stall", stall, 1);
        chk("lu_bubble", id_ex_bubble, 1);
        chk("lu_efa", ex_forward_a, 0);
        step();
        go(1, 9, 0, 1, 0, 0, 0, 0, 0);
        chk("lu_after_mfa", mem_forward_a, 1);
        chk("lu_after_stall", stall, 0);
        chk("lu_count", stall_count, 1);
        step(); nop2();

        // Register 0 never matches
        go(1, 0, 0, 0, 0, 0, 1, 1, 0); step();
        go(1, 0, 0, 1, 1, 0, 0, 0, 0);
        chk("r0_all", {ex_forward_a, ex_forward_b, mem_forward_a, mem_forward_b, stall}, 0);
        step(); nop2();

        // Flush wins over load-use
        go(1, 0, 0, 0, 0, 9, 1, 1, 0); step();
        go(1, 9, 0, 1, 0, 0, 0, 0, 1);
        chk("flush_stall", stall, 0);
        chk("flush_bubble", id_ex_bubble, 1);
        step();
        go(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("flush_count", stall_count, 1);
        step(); nop2();

        // Saturation on the 2-bit counter
        for (int i = 0; i < 5; i++) begin
            go(1, 0, 0, 0, 0, 12, 1, 1, 0); step();
            go(1, 0, 12, 0, 1, 0, 0, 0, 0); step();
            go(1, 0, 12, 0, 1, 0, 0, 0, 0); step();
        end
        go(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("sat_count2", s_count, 3);
        chk("sat_count16", stall_count, 6);
        step();

        // Reset during a stall drops stall immediately
        go(1, 0, 0, 0, 0, 9, 1, 1, 0); step();
        go(1, 9, 0, 1, 0, 0, 0, 0, 0);
        chk("midrst_stall_before", stall, 1);
        rst = 1'b0;
        model_clear();
        #1;
        chk("midrst_stall", stall, 0);
        chk("midrst_bubble", id_ex_bubble, 0);
        chk("midrst_count", stall_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        nop2();

        // Random traffic on a small register set to provoke frequent hits
        hold = 0;
        for (int i = 0; i < 600; i++) begin
            if (!hold) begin
                set_id($urandom_range(9) != 0, $urandom_range(7), $urandom_range(7),
                       1'($urandom), 1'($urandom), $urandom_range(7), 1'($urandom),
                       $urandom_range(2) == 0, 1'b0);
            end
            flush = ($urandom_range(11) == 0);
            @(negedge clk);
            compare_all();
            hold = stall;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
Control-side companion to the 5-stage pipelined datapath. It consumes ID-stage register usage, keeps a shadow pipeline of destination tags for the EX and MEM stages, and produces the datapath's forwarding selects (ex_forward_a/b, mem_forward_a/b). It also detects load-use hazards and emits stall/bubble control, and counts stall cycles for performance debug.

Parameters:
REG_ADDR_W, 5, register address width
CNT_W, 16, width of saturating stall counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
id_valid  in  1  ID stage holds a real instruction
id_rs  in  REG_ADDR_W  ID source register A
id_rt  in  REG_ADDR_W  ID source register B
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
id_dest  in  REG_ADDR_W  ID destination (post-RegDst select)
id_regwr  in  1  ID instruction writes the register file
id_memtoreg  in  1  ID instruction is a load
flush  in  1  squash ID instruction (branch/jump redirect)
ex_forward_a  out  1  select ALUout for operand A
ex_forward_b  out  1  select ALUout for operand B
mem_forward_a  out  1  select Dw for operand A
mem_forward_b  out  1  select Dw for operand B
stall  out  1  hold PC and IF/ID register this cycle
id_ex_bubble  out  1  load NOP controls into ID/EX this cycle
stall_count  out  CNT_W  number of stall cycles since reset, saturating

Behaviour:
- Shadow entries EX and MEM each hold {valid, dest, regwr, memtoreg}.
- Reset (rst=0, async): both entries valid=0; all fields 0; stall_count=0. All forward outputs, stall and id_ex_bubble read 0 while in reset.
- Define "writer hit" for stage S and source r: S.valid & S.regwr & (S.dest==r) & (r!=0) & use_r & id_valid.
- Forwarding outputs are combinational from the current inputs and the shadow state; they take effect in the same cycle.
- Forwarding selection, per operand independently:
  - EX hit on a non-load: ex_forward_x=1, mem_forward_x=0. EX takes priority over MEM because it holds the youngest value.
  - Otherwise, MEM hit (load or not): mem_forward_x=1.
  - Otherwise both are 0.
- Load-use: an EX hit where EX.memtoreg=1 on either used operand gives stall=1, id_ex_bubble=1. In this case ex_forward_x=0 for that operand, because ALUout is an address.
- flush=1: id_ex_bubble=1 and stall=0. If flush and load-use coincide, flush wins: stall=0, the instruction is squashed, and the counter is not incremented.
- Update on each rising clk:
  - MEM <= EX.
  - EX <= bubble (valid=0) if id_ex_bubble; otherwise {id_valid, id_dest, id_regwr, id_memtoreg}.
- Stall lasts exactly one cycle per load-use. On the next cycle the load sits in MEM, so the held ID instruction re-evaluates and gets mem_forward=1.
- stall_count increments by 1 on each clock where stall=1. It saturates at all-ones and does not wrap.
- dest==0 never produces a hit, even when regwr=1.
- Writeback-stage bypass is handled by the register file and is outside this block.
- If rst is asserted mid-stall, state clears immediately and stall drops asynchronously.

Test Plan:
- Reset: rst=0 with arbitrary inputs -> all outputs 0, stall_count=0. Release reset, apply id_valid=0 for 3 cycles -> outputs remain 0.
- EX forward: cycle0 ID add dest=5 regwr=1; cycle1 ID rs=5 use_rs=1 -> ex_forward_a=1, mem_forward_a=0, stall=0.
- MEM forward and priority: add dest=7, then nop, then ID rt=7 -> mem_forward_b=1. Sequence add dest=7, add dest=7, ID rs=7 -> ex_forward_a=1, mem_forward_a=0.
- Load-use: load dest=9 memtoreg=1, then ID rs=9 -> stall=1 and id_ex_bubble=1 for exactly one cycle, stall_count=1. The next cycle shows mem_forward_a=1, stall=0.
- Register 0: writer with dest=0 regwr=1 followed by ID rs=0 rt=0 -> all forwards 0, no stall.
- Flush vs. load-use, plus saturation: load-use with flush=1 -> stall=0, bubble=1, count unchanged. With CNT_W=2, 5 load-use events -> stall_count=3.
